qpu_mcu_measure_collect: RTL
============================

# qpu_mcu_measure_collect

Measurement result collector: the producer side of the measurement-result write port of the execute-stage register file. It accepts a measurement request carrying a qubit list, gathers per-qubit readout strobes from the readout front-end within a programmable timeout window, and emits a single-cycle write (`wen`, data, list) that commits all results for that request together. It sits between the measure dispatch/OITF path and the register file's measurement result registers.

## Interface

Parameters:
- `QUBIT_NUM`, default `QPU_QUBIT_NUM` (4): number of qubits; width of all list and data buses.
- `TMO_W`, default 16: width of the timeout count.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `meas_req_valid`  in  1  measurement request valid.
- `meas_req_ready`  out  1  request accepted when `valid & ready` at a rising edge.
- `meas_req_list`  in  QUBIT_NUM  qubits to measure; bit i set means qubit i.
- `meas_req_tmo`  in  TMO_W  timeout in cycles; sampled on accept.
- `rdout_valid`  in  QUBIT_NUM  per-qubit readout strobe, one cycle each.
- `rdout_data`  in  QUBIT_NUM  per-qubit result; bit i is valid only with `rdout_valid[i]`.
- `mcu_measure_o_wen`  out  1  one-cycle result write pulse; drives `mcu_measure_i_wen`.
- `mcu_measure_o_data`  out  QUBIT_NUM  collected results; drives `mcu_measure_i_data`.
- `mcu_measure_o_list`  out  QUBIT_NUM  request list for this write; drives the OITF measure-list return.
- `mcu_measure_o_tmo`  out  1  this write has at least one qubit with no strobe.
- `busy`  out  1  high in COLLECT or WRITE.

## Operation

- State machine: IDLE, COLLECT, WRITE.
- Registers: `pend` (QUBIT_NUM), `data_r`, `list_r`, `tmo_flag`, and counter `cnt` (TMO_W).
- IDLE:
  - `meas_req_ready=1`.
  - On accept with a nonzero list: `list_r<=list`, `pend<=list`, `data_r<=0`, `cnt<=meas_req_tmo`; go to COLLECT.
  - On accept with `list==0`: the request is consumed. No write occurs and the state stays IDLE.
- COLLECT, each cycle:
  - Capture set `hit = rdout_valid & pend`. For each set bit i: `data_r[i]<=rdout_data[i]` and clear `pend[i]`.
  - If `pend & ~hit == 0`: go to WRITE with `tmo_flag=0`.
  - Otherwise, if `cnt==0`: go to WRITE with `tmo_flag=1`.
  - Otherwise: `cnt<=cnt-1`.
- WRITE: outputs are presented for one cycle, then the state returns to IDLE.
- Data of qubits that timed out is 0.
- Strobes for qubits not in `pend` are ignored. This covers unrequested qubits, duplicates after capture, and any strobe in IDLE or WRITE. The first captured value wins.
- Simultaneous final strobe and `cnt==0`: completion wins, so `tmo_flag=0`.
- `meas_req_ready=0` in COLLECT and WRITE. A request held through WRITE is accepted in the first IDLE cycle.

## Timing

- Accept edge T: COLLECT is active from cycle T+1.
- COLLECT lasts at most `meas_req_tmo+1` cycles. With `tmo=0`, only strobes in the first COLLECT cycle count.
- The strobe completing the set is sampled at edge E. WRITE runs during cycle E+1, with `mcu_measure_o_wen=1` for exactly that cycle.
- Minimum accept-to-`wen` latency is 2 cycles. Minimum spacing between accepts is 3 cycles.
- Outputs:
  - All outputs are registered except `meas_req_ready` and `busy`, which decode the state.
  - `o_data`, `o_list` and `o_tmo` update at entry to WRITE. They hold their values until the next WRITE.
- Reset (asynchronous, any state including mid-COLLECT):
  - State goes to IDLE.
  - `wen`, `o_data`, `o_list`, `o_tmo`, `busy`, `pend` and `cnt` all go to 0.
  - `meas_req_ready=1`, but no transfer occurs while `rst` is high.
  - Partial results are discarded and no write is produced.

## Test plan

All scenarios use `QUBIT_NUM=4`.

1. **Normal completion.**
   - Stimulus: request list 0101, tmo 10. Then `q0=1` strobe at COLLECT cycle 2 and `q2=0` strobe at cycle 5.
   - Required: `wen` single pulse in cycle 6; data 0001, list 0101, tmo 0, `busy` low after.
2. **Timeout.**
   - Stimulus: list 1111, tmo 3, only `q1=1` strobed.
   - Required: `wen` after 4 COLLECT cycles; data 0010, tmo 1.
3. **Completion versus expiry.**
   - Stimulus: list 0001, tmo 2, `q0=1` strobe in the COLLECT cycle where `cnt==0`.
   - Required: data 0001, tmo 0.
4. **Stray and duplicate strobes.**
   - Stimulus: list 0011; strobe `q3=1`, then `q0=1`, then `q0=0` again, then `q1=1`.
   - Required: data 0011, `o_data[3]=0`, exactly one `wen`.
5. **Reset mid-COLLECT and back-to-back.**
   - Stimulus: assert `rst` during COLLECT with one qubit captured, then release.
   - Required: no `wen`, all outputs 0, ready 1.
   - Then: two held requests complete as two `wen` pulses, the second accepted in the IDLE cycle following WRITE.
6. **Zero list.**
   - Stimulus: request list 0000.
   - Required: accepted in one cycle, no `wen`, `busy` stays 0, ready remains 1.

Source files
------------

// File: rtl/qpu_mcu_measure_collect.sv
// Measurement result collector: gathers per-qubit readout strobes for one
// request and commits them as a single one-cycle register-file write.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   meas_req_valid/ready   request handshake (ready only in IDLE)
//   meas_req_list          qubits to measure (bit i = qubit i)
//   meas_req_tmo           timeout window in cycles, sampled on accept
//   rdout_valid/data       per-qubit readout strobe and result bit
//   mcu_measure_o_wen      one-cycle write pulse
//   mcu_measure_o_data     collected results (timed-out qubits read 0)
//   mcu_measure_o_list     request list belonging to this write
//   mcu_measure_o_tmo      at least one listed qubit never strobed
//   busy                   collecting or writing
module qpu_mcu_measure_collect #(
  parameter int QUBIT_NUM = 4,
  parameter int TMO_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 meas_req_valid,
  output logic                 meas_req_ready,
  input  logic [QUBIT_NUM-1:0] meas_req_list,
  input  logic [TMO_W-1:0]     meas_req_tmo,
  input  logic [QUBIT_NUM-1:0] rdout_valid,
  input  logic [QUBIT_NUM-1:0] rdout_data,
  output logic                 mcu_measure_o_wen,
  output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
  output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
  output logic                 mcu_measure_o_tmo,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [QUBIT_NUM-1:0] pend_q, pend_d;
  logic [QUBIT_NUM-1:0] data_q, data_d;
  logic [QUBIT_NUM-1:0] list_q, list_d;
  logic [TMO_W-1:0]     cnt_q, cnt_d;
  logic                 wen_q, wen_d;
  logic [QUBIT_NUM-1:0] o_data_q, o_data_d;
  logic [QUBIT_NUM-1:0] o_list_q, o_list_d;
  logic                 tmo_q, tmo_d;

  logic [QUBIT_NUM-1:0] hit;
  logic [QUBIT_NUM-1:0] rest;
  logic                 accept;

  assign meas_req_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);

  assign mcu_measure_o_wen  = wen_q;
  assign mcu_measure_o_data = o_data_q;
  assign mcu_measure_o_list = o_list_q;
  assign mcu_measure_o_tmo  = tmo_q;

  // Only still-pending qubits can be captured; everything else is stray.
  assign hit    = rdout_valid & pend_q;
  assign rest   = pend_q & ~hit;
  assign accept = meas_req_valid & meas_req_ready;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    data_d   = data_q;
    list_d   = list_q;
    cnt_d    = cnt_q;
    wen_d    = 1'b0;
    o_data_d = o_data_q;
    o_list_d = o_list_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        // An empty list is consumed without producing a write.
        if (accept && (meas_req_list != '0)) begin
          list_d  = meas_req_list;
          pend_d  = meas_req_list;
          data_d  = '0;
          cnt_d   = meas_req_tmo;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        data_d = (data_q & ~hit) | (rdout_data & hit);
        pend_d = rest;
        // Completion is tested first so a final strobe on the
        // expiry cycle still counts as a clean finish.
        if ((rest == '0) || (cnt_q == '0)) begin
          state_d  = S_WRITE;
          wen_d    = 1'b1;
          o_data_d = data_d;
          o_list_d = list_q;
          tmo_d    = (rest != '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      data_q   <= '0;
      list_q   <= '0;
      cnt_q    <= '0;
      wen_q    <= 1'b0;
      o_data_q <= '0;
      o_list_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      list_q   <= list_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      o_data_q <= o_data_d;
      o_list_q <= o_list_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule
